stopwatch_lap_n: RTL and testbench
==================================

// Module: stopwatch_lap_n
// PURPOSE
//  Parametrised successor to the service-3 stopwatch. A 4-digit BCD stopwatch with
//  start/stop, clear and lap capture into an N-entry circular lap buffer.
//  Sits under the service mux; drives the 16-bit BCD word to the 7-seg scanner.
//  Adds an internal prescaler, two display modes, lap recall and an overflow flag.
// PARAMETERS
//  TICK_DIV  16  clk cycles per count unit (>=1); unit = 1 s in MODE 0, 10 ms in MODE 1
//  MODE      0   0: MM:SS (digit limits 5,9,5,9); 1: SS:CC (5,9,9,9)
//  NUM_LAPS  4   lap buffer depth (>=1); LSEL_W = max(1,$clog2(NUM_LAPS))
// PORTS
//  clk         in   1        system clock; all state changes on rising edge
//  reset       in   1        asynchronous, active-high; clears all state
//  SPDT3       in   1        service enable; low = freeze and blank
//  push_m      in   1        start/stop button, level; rising edge acts
//  push_l      in   1        lap (RUN) / clear (PAUSE, IDLE) button, level; rising edge acts
//  view_lap    in   1        1 = display lap buffer entry instead of live time
//  lap_sel     in   LSEL_W   lap index, 0 = most recent
//  segments    out  16       BCD {d3,d2,d1,d0}, d0 least significant
//  running     out  1        1 while in RUN
//  lap_count   out  LSEL_W+1 valid laps stored, saturates at NUM_LAPS
//  overflow    out  1        sticky: time wrapped past max
// BEHAVIOUR
//  Reset: state=IDLE, time=0, prescaler=0, lap buffer/ptr/count=0, overflow=0;
//   segments=16'h0000, running=0. Reset may assert mid-run; takes effect immediately.
//  Edge detect: push_m/push_l registered once; edge = cur & ~prev. Prev regs update
//   even when SPDT3=0, so a held button gives no edge on re-enable.
//  SPDT3=0: edges ignored, prescaler and time frozen, state held, segments=0.
//  FSM (IDLE, RUN, PAUSE):
//   IDLE  --m_edge--> RUN;   l_edge: clear (no-op on zero time)
//   RUN   --m_edge--> PAUSE; l_edge: capture lap
//   PAUSE --m_edge--> RUN;   l_edge: clear -> IDLE
//  Clear: time=0, prescaler=0, lap count/ptr=0, overflow=0. Buffer contents may remain.
//  Simultaneous in RUN: lap captures pre-increment time AND go to PAUSE.
//  Simultaneous in PAUSE/IDLE: push_m wins, clear suppressed.
//  Prescaler: counts only in RUN, 0..TICK_DIV-1; tick on the cycle it equals
//   TICK_DIV-1 (wraps to 0). Holds in PAUSE, so resume continues the partial unit.
//  Time: on tick d0++; each digit wraps at its limit and carries into the next.
//   Max 59:59 (MODE 0) or 59:99 (MODE 1) wraps to 00:00 and sets overflow.
//   Counting continues after wrap.
//  Lap capture: buf[wr_ptr]=time; wr_ptr=(wr_ptr+1) mod NUM_LAPS; lap_count++ sat.
//   When full, the oldest entry is overwritten.
//  Display (combinational from regs): view_lap=0 -> time.
//   view_lap=1 -> buf[(wr_ptr-1-lap_sel) mod NUM_LAPS] if lap_sel<lap_count, else 0.
//  Latency: edge at cycle t -> state/running change at t+2. A tick updates time and
//   segments on the same clock edge.
// STRUCTURE
//  Package stopwatch_pkg: FSM state encoding; per-MODE digit limit constants; BCD width.
//  Sub-module bcd_digit_ctr (param MAX): 4-bit digit, inc_in, clr, carry_out = inc_in & (q==MAX).
//   Instantiated 4x. Lap buffer is a flat register array; FSM, prescaler and edge detect in top.
// TESTING (TICK_DIV=4, MODE=0, NUM_LAPS=4 unless noted)
//  1 reset mid-run at 00:07 -> segments=0000, running=0, lap_count=0 asynchronously.
//  2 start, 244 clk -> segments=16'h0101; m_edge -> PAUSE; 40 clk -> still 0101;
//    resume, 4 clk -> 0102.
//  3 laps at 00:03,00:05,00:08,00:10,00:12 -> lap_count=4; lap_sel 0..3 = 0012,0010,0008,0005;
//    lap_sel above lap_count -> 0000.
//  4 run past 59:59 -> 0000, overflow=1; pause + l_edge -> IDLE, overflow=0, lap_count=0.
//  5 push_m+push_l same cycle in RUN at 00:04 -> PAUSE, lap0=0004; same in PAUSE -> RUN, no clear.
//  6 SPDT3=0 while RUN for 100 clk -> segments=0, time frozen, pushes ignored;
//    re-enable -> resumes from frozen value.
//    MODE=1: 100 units -> 16'h0100.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and digit limits for the BCD lap stopwatch.
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int BCD_W  = 4;
  localparam int DIGITS = 4;

  // Per-digit maximum value packed as {d3,d2,d1,d0}.
  localparam logic [15:0] LIM_MODE0 = 16'h5959;
  localparam logic [15:0] LIM_MODE1 = 16'h5999;

  function automatic logic [BCD_W-1:0] digit_max(input int mode, input int idx);
    logic [15:0] lim;
    lim = (mode == 0) ? LIM_MODE0 : LIM_MODE1;
    return lim[idx*BCD_W +: BCD_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_ctr.sv
// bcd_digit_ctr: one BCD digit that wraps at MAX and forwards a carry.
`default_nettype none

module bcd_digit_ctr
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = 4'd9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_in,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  assign carry_out = inc_in & (q == MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc_in) begin
      q <= (q == MAX) ? '0 : q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stopwatch_lap_n.sv
// stopwatch_lap_n: 4-digit BCD stopwatch with start/stop, clear, prescaler,
// overflow flag and an N-entry circular lap buffer with recall.
`default_nettype none

module stopwatch_lap_n
  import stopwatch_pkg::*;
#(
  parameter  int TICK_DIV = 16,
  parameter  int MODE     = 0,
  parameter  int NUM_LAPS = 4,
  localparam int LSEL_W   = (NUM_LAPS > 1) ? $clog2(NUM_LAPS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SPDT3,
  input  logic              push_m,
  input  logic              push_l,
  input  logic              view_lap,
  input  logic [LSEL_W-1:0] lap_sel,
  output logic [15:0]       segments,
  output logic              running,
  output logic [LSEL_W:0]   lap_count,
  output logic              overflow
);

  localparam int                PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [LSEL_W-1:0] PTR_LAST = LSEL_W'(NUM_LAPS - 1);
  localparam logic [LSEL_W:0]   CNT_MAX  = (LSEL_W + 1)'(NUM_LAPS);

  state_t            state;
  logic [PW-1:0]     presc;
  logic [LSEL_W-1:0] wr_ptr;
  logic [15:0]       lap_buf [NUM_LAPS];
  logic [15:0]       cur_time;
  logic [DIGITS:0]   inc;
  logic              m_cur, m_prev, l_cur, l_prev;
  logic              m_edge, l_edge, tick, wrap, do_lap, do_clear;
  logic [LSEL_W:0]   rd_full;
  logic [15:0]       lap_word;

  // Button history keeps updating while disabled so a held button cannot fire on re-enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cur  <= 1'b0;
      m_prev <= 1'b0;
      l_cur  <= 1'b0;
      l_prev <= 1'b0;
    end else begin
      m_cur  <= push_m;
      m_prev <= m_cur;
      l_cur  <= push_l;
      l_prev <= l_cur;
    end
  end

  assign m_edge   = SPDT3 & m_cur & ~m_prev;
  assign l_edge   = SPDT3 & l_cur & ~l_prev;
  assign tick     = SPDT3 && (state == ST_RUN) && (presc == PRE_LAST);
  assign do_lap   = l_edge && (state == ST_RUN);
  assign do_clear = l_edge && !m_edge && (state != ST_RUN);

  assign inc[0] = tick;
  assign wrap   = inc[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_ctr #(.MAX(digit_max(MODE, i))) u_digit (
      .clk       (clk),
      .reset     (reset),
      .inc_in    (inc[i]),
      .clr       (do_clear),
      .q         (cur_time[i*BCD_W +: BCD_W]),
      .carry_out (inc[i+1])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      running   <= 1'b0;
      presc     <= '0;
      wr_ptr    <= '0;
      lap_count <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < NUM_LAPS; i++) lap_buf[i] <= '0;
    end else begin
      if (m_edge) begin
        case (state)
          ST_RUN: begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end
          default: begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        endcase
      end
      if (SPDT3 && state == ST_RUN) presc <= tick ? '0 : presc + 1'b1;
      if (wrap) overflow <= 1'b1;
      // The lap captures the time held before this edge's tick lands.
      if (do_lap) begin
        for (int i = 0; i < NUM_LAPS; i++)
          if (wr_ptr == LSEL_W'(i)) lap_buf[i] <= cur_time;
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        if (lap_count != CNT_MAX) lap_count <= lap_count + 1'b1;
      end
      if (do_clear) begin
        state     <= ST_IDLE;
        running   <= 1'b0;
        presc     <= '0;
        wr_ptr    <= '0;
        lap_count <= '0;
        overflow  <= 1'b0;
      end
    end
  end

  // Recall index (wr_ptr-1-lap_sel) mod NUM_LAPS, kept non-negative by adding NUM_LAPS first.
  always_comb begin
    rd_full = {1'b0, wr_ptr} + CNT_MAX - 1'b1 - {1'b0, lap_sel};
    if (rd_full >= CNT_MAX) rd_full = rd_full - CNT_MAX;
    lap_word = '0;
    for (int i = 0; i < NUM_LAPS; i++)
      if (rd_full == (LSEL_W + 1)'(i)) lap_word = lap_buf[i];
    if ({1'b0, lap_sel} >= lap_count) lap_word = '0;
    if (!SPDT3)        segments = '0;
    else if (view_lap) segments = lap_word;
    else               segments = cur_time;
  end

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_lap_n.sv
// tb_stopwatch_lap_n: directed self-checking bench, MODE 0 main instance plus a MODE 1 instance.
`default_nettype none

module tb_stopwatch_lap_n;

  logic        clk = 1'b0;
  logic        reset, spdt3, push_m, push_l, view_lap;
  logic [1:0]  lap_sel;
  logic [15:0] segments;
  logic        running, overflow;
  logic [2:0]  lap_count;

  logic        reset2, spdt3_2, push_m2;
  logic [15:0] segments2;
  logic        running2, overflow2;
  logic [2:0]  lap_count2;

  int total  = 0;
  int passes = 0;

  always #5 clk = ~clk;

  stopwatch_lap_n #(.TICK_DIV(4), .MODE(0), .NUM_LAPS(4)) dut (
    .clk(clk), .reset(reset), .SPDT3(spdt3), .push_m(push_m), .push_l(push_l),
    .view_lap(view_lap), .lap_sel(lap_sel), .segments(segments),
    .running(running), .lap_count(lap_count), .overflow(overflow)
  );

  stopwatch_lap_n #(.TICK_DIV(4), .MODE(1), .NUM_LAPS(4)) dut_m1 (
    .clk(clk), .reset(reset2), .SPDT3(spdt3_2), .push_m(push_m2), .push_l(1'b0),
    .view_lap(1'b0), .lap_sel(2'd0), .segments(segments2),
    .running(running2), .lap_count(lap_count2), .overflow(overflow2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds the chosen buttons across exactly one rising edge.
  task automatic press(input logic m, input logic l);
    push_m = m;
    push_l = l;
    @(negedge clk);
    push_m = 1'b0;
    push_l = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // After this the FSM is in RUN with prescaler 0.
  task automatic start();
    press(1'b1, 1'b0);
    wait_cyc(1);
  endtask

  // From (T, prescaler 0): captures T and leaves (T+1, prescaler 0).
  task automatic lap();
    press(1'b0, 1'b1);
    wait_cyc(3);
  endtask

  task automatic view(input logic [1:0] sel, input logic [15:0] exp, input string tag);
    view_lap = 1'b1;
    lap_sel  = sel;
    #1;
    check(tag, segments, exp);
    view_lap = 1'b0;
  endtask

  initial begin
    reset = 1'b1; spdt3 = 1'b1; push_m = 1'b0; push_l = 1'b0;
    view_lap = 1'b0; lap_sel = 2'd0;
    reset2 = 1'b1; spdt3_2 = 1'b1; push_m2 = 1'b0;
    wait_cyc(2);
    reset = 1'b0;
    reset2 = 1'b0;
    check("rst_segments", segments, 16'h0000);
    check("rst_running", running, 0);
    check("rst_lap_count", lap_count, 0);
    check("rst_overflow", overflow, 0);

    // Asynchronous reset in the middle of a run
    start();
    check("t1_running", running, 1);
    wait_cyc(12);
    lap();
    check("t1_lap_count", lap_count, 1);
    wait_cyc(12);
    check("t1_time7", segments, 16'h0007);
    reset = 1'b1;
    #1;
    check("t1_async_seg", segments, 16'h0000);
    check("t1_async_run", running, 0);
    check("t1_async_laps", lap_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // Count, pause holds, resume keeps the partial unit
    start();
    wait_cyc(244);
    check("t2_time61", segments, 16'h0101);
    press(1'b1, 1'b0);
    wait_cyc(1);
    check("t2_paused", running, 0);
    wait_cyc(40);
    check("t2_hold", segments, 16'h0101);
    press(1'b1, 1'b0);
    wait_cyc(1);
    check("t2_resumed", running, 1);
    wait_cyc(1);
    check("t2_partial", segments, 16'h0101);
    wait_cyc(1);
    check("t2_time62", segments, 16'h0102);

    // Laps and recall
    do_reset();
    start();
    wait_cyc(12);
    lap();
    wait_cyc(4);
    lap();
    check("t3_count2", lap_count, 2);
    view(2'd0, 16'h0005, "t3_two_sel0");
    view(2'd1, 16'h0003, "t3_two_sel1");
    view(2'd2, 16'h0000, "t3_sel_beyond");
    wait_cyc(8);
    lap();
    wait_cyc(4);
    lap();
    wait_cyc(4);
    lap();
    check("t3_count_sat", lap_count, 4);
    view(2'd0, 16'h0012, "t3_sel0");
    view(2'd1, 16'h0010, "t3_sel1");
    view(2'd2, 16'h0008, "t3_sel2");
    view(2'd3, 16'h0005, "t3_sel3");
    #1;
    check("t3_live", segments, 16'h0013);

    // Wrap past 59:59, then pause and clear
    do_reset();
    start();
    wait_cyc(8);
    lap();
    wait_cyc(4 * 3596);
    check("t4_max", segments, 16'h5959);
    check("t4_no_ovf", overflow, 0);
    wait_cyc(4);
    check("t4_wrap", segments, 16'h0000);
    check("t4_ovf", overflow, 1);
    wait_cyc(4);
    check("t4_continues", segments, 16'h0001);
    press(1'b1, 1'b0);
    wait_cyc(1);
    press(1'b0, 1'b1);
    wait_cyc(1);
    check("t4_clr_seg", segments, 16'h0000);
    check("t4_clr_ovf", overflow, 0);
    check("t4_clr_laps", lap_count, 0);
    check("t4_idle", running, 0);

    // Both buttons together in RUN, then in PAUSE
    do_reset();
    start();
    wait_cyc(16);
    press(1'b1, 1'b1);
    wait_cyc(1);
    check("t5_paused", running, 0);
    check("t5_lap_count", lap_count, 1);
    view(2'd0, 16'h0004, "t5_lap0");
    press(1'b1, 1'b1);
    wait_cyc(1);
    check("t5_resumed", running, 1);
    check("t5_no_clear_laps", lap_count, 1);
    check("t5_no_clear_time", segments, 16'h0004);

    // Service disable freezes everything and ignores pushes
    do_reset();
    start();
    wait_cyc(20);
    spdt3 = 1'b0;
    #1;
    check("t6_blank", segments, 16'h0000);
    wait_cyc(10);
    press(1'b1, 1'b0);
    wait_cyc(10);
    press(1'b0, 1'b1);
    wait_cyc(78);
    spdt3 = 1'b1;
    #1;
    check("t6_frozen", segments, 16'h0005);
    check("t6_still_run", running, 1);
    check("t6_no_lap", lap_count, 0);
    wait_cyc(4);
    check("t6_resume", segments, 16'h0006);

    // MODE 1: SS:CC, hundredths digit pair counts to 99
    push_m2 = 1'b1;
    @(negedge clk);
    push_m2 = 1'b0;
    wait_cyc(1);
    check("m1_running", running2, 1);
    wait_cyc(396);
    check("m1_99", segments2, 16'h0099);
    wait_cyc(4);
    check("m1_100", segments2, 16'h0100);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
